seq_shifter: RTL and testbench

SEQ_SHIFTER -- requirements
Module: seq_shifter

---
 rtl/shifter_pkg.sv | 42 ++++
 rtl/shift_step.sv | 27 ++
 rtl/seq_shifter.sv | 81 ++++++++
 tb/tb_seq_shifter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the sequential shifter: widths, operation encodings, FSM states.
// Build option SEQ_SHIFTER_ROTATE_EN turns operation 00 into rotate-right.
package shifter_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    OP_ROR = 2'b00,
    OP_SLL = 2'b01,
    OP_SRL = 2'b10,
    OP_SRA = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0]    op1;
    logic [SHAMT_W-1:0] shamt;
    op_e                op;
  } req_t;

  // Bit shifted in on every step; only SRA replicates the captured sign.
  function automatic logic fill_bit(input op_e op, input logic msb);
    return (op == OP_SRA) ? msb : 1'b0;
  endfunction

  // Initial working value. Without rotate support, operation 00 runs the
  // normal timing on an all-zero word so it completes with a zero result.
  function automatic logic [XLEN-1:0] load_word(input op_e op, input logic [XLEN-1:0] op1);
`ifdef SEQ_SHIFTER_ROTATE_EN
    load_word = op1;
`else
    load_word = (op == OP_ROR) ? '0 : op1;
`endif
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit step of the shifter datapath.
// With SEQ_SHIFTER_ROTATE_EN defined, operation 00 rotates right by one.
module shift_step
  import shifter_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  op_e             operation,
  input  logic            fill,
  output logic [XLEN-1:0] shifted
);

  always_comb begin
    shifted = word;
    unique case (operation)
      OP_SLL: shifted = {word[XLEN-2:0], fill};
      OP_SRL,
      OP_SRA: shifted = {fill, word[XLEN-1:1]};
`ifdef SEQ_SHIFTER_ROTATE_EN
      OP_ROR: shifted = {word[0], word[XLEN-1:1]};
`else
      OP_ROR: shifted = '0;
`endif
      default: shifted = word;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle barrel-less shifter: one bit per clock, valid/ready on both sides.
// Build option SEQ_SHIFTER_ROTATE_EN enables rotate-right on operation 00.
module seq_shifter
  import shifter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    op1,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         operation,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    res,
  output logic               busy
);

  state_e             state, state_nxt;
  logic [SHAMT_W-1:0] cnt;
  logic [XLEN-1:0]    work;
  logic [XLEN-1:0]    work_step;
  op_e                op_q;
  logic               fill_q;
  logic               accept;
  op_e                op_in;

  assign op_in  = op_e'(operation);
  assign accept = in_valid && in_ready;

  shift_step u_step (
    .word      (work),
    .operation (op_q),
    .fill      (fill_q),
    .shifted   (work_step)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = (shamt == '0) ? S_DONE : S_SHIFT;
      S_SHIFT: if (cnt == SHAMT_W'(1)) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      work   <= '0;
      op_q   <= OP_SLL;
      fill_q <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            work   <= load_word(op_in, op1);
            cnt    <= shamt;
            op_q   <= op_in;
            fill_q <= fill_bit(op_in, op1[XLEN-1]);
          end
        end
        S_SHIFT: begin
          work <= work_step;
          cnt  <= cnt - SHAMT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // in_ready is gated by rst_n so nothing is taken while reset is held.
  assign in_ready  = (state == S_IDLE) && rst_n;
  assign busy      = (state == S_SHIFT);
  assign out_valid = (state == S_DONE);
  assign res       = out_valid ? work : '0;

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: driver pushes expected result and arrival cycle,
// a negedge monitor pops and checks whenever out_valid is presented.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] op1 = '0;
  logic [4:0]  shamt = '0;
  logic [1:0]  operation = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] res;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit or_force = 1'b0;
  bit or_val = 1'b0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;
  exp_t q[$];

  seq_shifter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .shamt     (shamt),
    .operation (operation),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = or_force ? or_val : ($urandom_range(0, 1) == 1);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model(input logic [31:0] a, input int s, input logic [1:0] op);
    case (op)
      2'b01: return a << s;
      2'b10: return a >> s;
      2'b11: return $unsigned($signed(a) >>> s);
`ifdef SEQ_SHIFTER_ROTATE_EN
      default: return (a >> s) | (a << (32 - s));
`else
      default: return 32'h0;
`endif
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: first DONE cycle pops the scoreboard; later DONE cycles check hold.
  bit          in_done = 1'b0;
  logic [31:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_done = 1'b0;
    end else if (out_valid) begin
      if (!in_done) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got %h with nothing expected", res);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result", res, e.res);
          chk("latency", cyc, e.cyc);
        end
        held    = res;
        in_done = 1'b1;
      end else begin
        chk("hold_res", res, held);
      end
      chk("in_ready_in_done", {31'b0, in_ready}, 32'h0);
      chk("busy_in_done", {31'b0, busy}, 32'h0);
      if (out_ready) in_done = 1'b0;
    end else begin
      chk("res_zero_idle", res, 32'h0);
    end
  end

  task automatic send(input logic [31:0] a, input int s, input logic [1:0] op);
    int  w = 0;
    exp_t e;
    @(negedge clk);
    in_valid  = 1'b1;
    op1       = a;
    shamt     = 5'(s);
    operation = op;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
      in_valid = 1'b0;
      return;
    end
    e.res = model(a, s, op);
    e.cyc = cyc + 1 + s;
    q.push_back(e);
    @(negedge clk);
    in_valid  = 1'b0;
    op1       = $urandom;
    shamt     = 5'($urandom_range(0, 31));
    operation = 2'($urandom_range(0, 3));
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  initial begin
    bit seen;
    int n;

    // Reset behaviour
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_res", res, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'h1);

    // Directed values
    send(32'h0000_0001, 4, 2'b01);
    send(32'h8000_0000, 4, 2'b11);
    send(32'h8000_0000, 31, 2'b11);
    send(32'h8000_0000, 31, 2'b10);
    send(32'h0000_0001, 1, 2'b00);
    for (int op = 0; op < 4; op++) begin
      send(32'hDEAD_BEEF, 0, 2'(op));
      chk("busy_shamt0", {31'b0, busy}, 32'h0);
    end
    drain();

    // Backpressure in DONE and in_valid noise while shifting
    or_force = 1'b1;
    or_val   = 1'b0;
    @(negedge clk);
    send(32'h1234_5678, 6, 2'b10);
    repeat (3) begin
      chk("busy_shift", {31'b0, busy}, 32'h1);
      in_valid = 1'b1;
      op1      = $urandom;
      shamt    = 5'd0;
      @(negedge clk);
    end
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_done", {31'b0, out_valid}, 32'h1);
    repeat (10) @(negedge clk);
    chk("held_valid", {31'b0, out_valid}, 32'h1);
    in_valid = 1'b0;
    or_val   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("release_out_valid", {31'b0, out_valid}, 32'h0);
    chk("release_in_ready", {31'b0, in_ready}, 32'h1);
    or_force = 1'b0;
    drain();

    // Reset in the middle of a long shift
    send(32'hFFFF_FFFF, 20, 2'b10);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    chk("abort_out_valid", {31'b0, out_valid}, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_in_ready", {31'b0, in_ready}, 32'h0);
    chk("abort_res", res, 32'h0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_result", {31'b0, seen}, 32'h0);
    chk("abort_in_ready_after", {31'b0, in_ready}, 32'h1);

    // Random traffic against the reference model
    for (int i = 0; i < 1500; i++)
      send($urandom, $urandom_range(0, 31), 2'($urandom_range(0, 3)));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
